axi_io_pmp_err_slv: RTL
=======================

Name: axi_io_pmp_err_slv

Overview:
- AXI4 error responder that terminates transactions the IO-PMP denies.
- The IO-PMP steers each rejected AW/AR burst (with its W beats) to this block instead of the downstream master port.
- The block completes each burst protocol-correctly: it consumes W data, returns an error B response, or returns arlen+1 error R beats.
- It keeps saturating counters of denied reads and writes for debug.

Parameters:
- DATA_WIDTH, 64, width of rdata in bits.
- ID_WIDTH, 8, width of AXI id fields.
- ERR_RESP, 2'b10, response code on B and R (SLVERR; 2'b11 selects DECERR).
- CNT_WIDTH, 32, width of the denial counters.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous active-high reset.
- s_axi_awid  input  ID_WIDTH  write address id.
- s_axi_awvalid  input  1  write address valid.
- s_axi_awready  output  1  write address ready.
- s_axi_wlast  input  1  last write beat.
- s_axi_wvalid  input  1  write data valid.
- s_axi_wready  output  1  write data ready.
- s_axi_bid  output  ID_WIDTH  write response id.
- s_axi_bresp  output  2  write response code.
- s_axi_bvalid  output  1  write response valid.
- s_axi_bready  input  1  write response ready.
- s_axi_arid  input  ID_WIDTH  read address id.
- s_axi_arlen  input  8  read burst length minus one.
- s_axi_arvalid  input  1  read address valid.
- s_axi_arready  output  1  read address ready.
- s_axi_rid  output  ID_WIDTH  read id.
- s_axi_rdata  output  DATA_WIDTH  read data; always zero.
- s_axi_rresp  output  2  read response code.
- s_axi_rlast  output  1  last read beat.
- s_axi_rvalid  output  1  read valid.
- s_axi_rready  input  1  read ready.
- denied_wr_cnt  output  CNT_WIDTH  count of accepted write bursts.
- denied_rd_cnt  output  CNT_WIDTH  count of accepted read bursts.

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active-high (rst). All state lives in registers, and all outputs decode directly from registers (no input-to-output combinational path).
- Reset values:
  - awready=1, arready=1.
  - wready=0, bvalid=0, rvalid=0, rlast=0.
  - bid=0, rid=0.
  - Both counters=0.
  - Write FSM=W_IDLE, read FSM=R_IDLE.
- bresp and rresp are constantly ERR_RESP. rdata is constantly 0. AW/AR fields other than id/len are not inputs; the parent leaves them unconnected.
- Write FSM:
  - W_IDLE: awready=1. On an AW handshake, register awid into bid and go to W_DATA.
  - W_DATA: wready=1. Each W handshake is discarded. A handshake with wlast=1 goes to W_RESP.
  - W_RESP: bvalid=1. bvalid holds until bready; on the handshake, go to W_IDLE.
- Write timing and corner cases:
  - awready is 0 outside W_IDLE; wready is 0 outside W_DATA. W beats arriving before their AW stall, which is legal AXI.
  - The burst ends on wlast only; awlen is not checked.
  - Latency: wready rises the cycle after the AW handshake. bvalid rises the cycle after the wlast handshake. awready returns the cycle after the B handshake.
  - Single-beat burst (wlast on the first beat): W_DATA lasts one cycle.
- Read FSM:
  - R_IDLE: arready=1. On an AR handshake, register arid into rid and arlen into an 8-bit beat counter, then go to R_DATA.
  - R_DATA: rvalid=1, rlast=(cnt==0). On an R handshake: if cnt==0 go to R_IDLE, else decrement cnt.
- Read timing and corner cases:
  - rid, rlast and rvalid are stable while rvalid=1 and rready=0.
  - First R beat is valid the cycle after the AR handshake; arready returns the cycle after the last R handshake.
  - arlen=0 gives one beat with rlast=1. arlen=255 gives 256 beats, and the counter never wraps.
- Channel independence: the read and write FSMs run concurrently. Simultaneous AW and AR handshakes are both accepted in the same cycle.
- Counters:
  - denied_wr_cnt increments on each AW handshake; denied_rd_cnt increments on each AR handshake.
  - Each saturates at 2^CNT_WIDTH-1 and does not wrap. Both update in the same cycle when both handshakes coincide.
  - Reset is the only clear.
- Reset mid-burst: the FSMs return to idle, all valids/readies return to their reset values, and the outstanding transaction is dropped. The parent is responsible for resetting the initiator alongside this block.

Test Plan:
- Single write: AW id=0x5A, then 4 W beats with wlast on the 4th, bready=1 → wready from cycle after AW; bvalid=1, bid=0x5A, bresp=2'b10 one cycle after the 4th beat; denied_wr_cnt=1.
- Read arlen=3, id=0x21, rready toggled 1/0 each cycle → exactly 4 R beats, rid=0x21, rdata=0, rresp=2'b10, rlast only on the 4th; outputs held during rready=0 cycles; arready=1 the cycle after the last beat.
- Boundary read arlen=255 with rready=1 → 256 consecutive beats, rlast on beat 256 only; arlen=0 → single beat with rlast=1.
- Simultaneous AW (id 3) and AR (id 7, arlen=1) in the same cycle, with bready=0 for 5 cycles → both accepted; R beats complete while bvalid is held with bid=3; both counters=1.
- W before AW: wvalid=1, wlast=1 asserted 3 cycles ahead of awvalid → wready=0 until the cycle after the AW handshake, then one beat consumed and B returned.
- Reset during R_DATA at beat 2 of 4 → next cycle rvalid=0, arready=1, counters=0; a new AR arlen=0 then completes normally. Separately, force counters to max → they stay at max after a further handshake.

Source files
------------

// File: rtl/axi_io_pmp_err_slv.sv
// AXI4 error responder for bursts the IO-PMP denies.
// Writes: W data is consumed and discarded, then an error B response is returned.
// Reads: arlen+1 beats of zero data are returned, each with an error response.
// Two saturating counters record how many write and read bursts were accepted.
module axi_io_pmp_err_slv #(
    parameter int         DATA_WIDTH = 64,
    parameter int         ID_WIDTH   = 8,
    parameter logic [1:0] ERR_RESP   = 2'b10,
    parameter int         CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [7:0]            s_axi_arlen,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [CNT_WIDTH-1:0]  denied_wr_cnt,
    output logic [CNT_WIDTH-1:0]  denied_rd_cnt
);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    w_state_t   w_state;
    r_state_t   r_state;
    logic [7:0] beat_cnt;
    logic       aw_hs;
    logic       ar_hs;

    // The readies are registered, so both handshakes depend only on flops and input valids.
    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;

    // Denied transactions always get the same error code and zero data.
    assign s_axi_bresp = ERR_RESP;
    assign s_axi_rresp = ERR_RESP;
    assign s_axi_rdata = '0;

    // Write channel FSM: accept AW, drain W until wlast, then hold B until bready.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        s_axi_bid     <= s_axi_awid;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid && s_axi_wready && s_axi_wlast) begin
                        s_axi_wready <= 1'b0;
                        s_axi_bvalid <= 1'b1;
                        w_state      <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_axi_bvalid && s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: begin
                    w_state       <= W_IDLE;
                    s_axi_awready <= 1'b1;
                    s_axi_wready  <= 1'b0;
                    s_axi_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Read channel FSM: accept AR, then stream arlen+1 beats, flagging the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            beat_cnt      <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        s_axi_rid     <= s_axi_arid;
                        beat_cnt      <= s_axi_arlen;
                        s_axi_arready <= 1'b0;
                        s_axi_rvalid  <= 1'b1;
                        s_axi_rlast   <= (s_axi_arlen == 8'd0);
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rvalid && s_axi_rready) begin
                        if (beat_cnt == 8'd0) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            beat_cnt    <= beat_cnt - 8'd1;
                            s_axi_rlast <= (beat_cnt == 8'd1);
                        end
                    end
                end
                default: begin
                    r_state       <= R_IDLE;
                    s_axi_arready <= 1'b1;
                    s_axi_rvalid  <= 1'b0;
                    s_axi_rlast   <= 1'b0;
                end
            endcase
        end
    end

    // Saturating denial counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            denied_wr_cnt <= '0;
            denied_rd_cnt <= '0;
        end else begin
            if (aw_hs && (denied_wr_cnt != CNT_MAX)) begin
                denied_wr_cnt <= denied_wr_cnt + CNT_WIDTH'(1);
            end
            if (ar_hs && (denied_rd_cnt != CNT_MAX)) begin
                denied_rd_cnt <= denied_rd_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
